bus_master_arbiter: RTL and testbench
=====================================

Name: bus_master_arbiter

Overview:
- Shares the single system bus (ROM/RAM/JTAG-UART/keyboard slaves) between two masters.
  - Master 0: the CPU load/store port.
  - Master 1: the interrupt service engine (keyboard read, UART echo).
- Round-robin arbitration, one transaction in flight, fixed single-cycle slave strobes.
- Captures read data after a configurable latency and returns it to the winning master with a one-cycle ack.
- Sits between the masters and the bus address decoder.

Parameters:
- AW, 64, address width on master and bus sides.
- DW, 64, data width on master and bus sides.
- RD_LATENCY, 0, cycles between the bus read strobe and valid bus_read_data. 0 means combinational slave. Range 0..7.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  master 0 write(1)/read(0).
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_rdata  out  DW  master 0 read data; valid while m0_ack=1.
- m0_ack  out  1  master 0 completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1.
- bus_address  out  AW  registered address to the slaves.
- bus_write_data  out  DW  registered write data.
- bus_write_enable  out  1  one-cycle write strobe.
- bus_read_enable  out  1  one-cycle read strobe.
- bus_read_data  in  DW  slave read data.
- grant  out  2  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; all outputs are 0; last_grant=1, so master 0 wins the first tie.
  - An in-flight transaction is dropped with no ack and no further strobes.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high at the clock edge, choose the winner.
    - Only one requester: it wins.
    - Both requesting: the master other than last_grant wins.
  - Register the winner's addr, wdata and we into bus_address/bus_write_data; set grant; go to ISSUE.
  - With no request, stay in IDLE; bus outputs hold their last values and the strobes stay 0.
- ISSUE (exactly one cycle):
  - bus_write_enable=we, or bus_read_enable=~we.
  - Write: go to RESP.
  - Read with RD_LATENCY=0: capture bus_read_data at this edge, then go to RESP.
  - Read with RD_LATENCY>0: load counter=RD_LATENCY-1, then go to WAIT.
- WAIT:
  - Strobes are 0.
  - When counter==0, capture bus_read_data and go to RESP; otherwise decrement.
- RESP (exactly one cycle):
  - Assert the winner's ack.
  - Drive the winner's rdata with the captured value on reads, and 0 on writes.
  - The other master's ack and rdata stay 0.
  - Set last_grant to the winner; clear grant; go to IDLE.
- Latency from req sampled in IDLE to ack cycle:
  - Writes: 2 cycles.
  - Reads: 2+RD_LATENCY cycles.
- Back-to-back rate is one transaction per 3+RD_LATENCY cycles.
- Master rules:
  - A master drops req in the cycle after seeing ack; a req still high in IDLE is a new transaction.
  - Deasserting req mid-transaction does not abort it; the ack is still pulsed.
  - Changes to addr/wdata/we after the grant edge are ignored, because the values are registered.
- Fairness: while both masters hold req continuously, grants alternate 0,1,0,1. A master never waits more than one transaction of the other.
- Strobes are never both high. At most one ack is high per cycle.

Decomposition:
- Package cpu_bus_pkg holds:
  - The state enum {IDLE, ISSUE, WAIT, RESP}.
  - Master index constants M_CPU=0, M_IRQ=1.
  - The address map constants Rom_base, Ram_base, Stk_base, Art_base=32'h8000_0000 and Key_base=32'h8000_0010, used by the decoder and the bench.
- Sub-module rr_arb2 holds the two-input round-robin pick: combinational winner from req[1:0] and last_grant.

Test Plan:
- Single read, RD_LATENCY=0: m0 reads 0x1004 with a slave returning 0x0000_0000_0000_1337.
  - bus_read_enable pulses in cycle 1.
  - m0_ack with m0_rdata=0x1337 in cycle 2.
  - m1_ack stays 0.
- Single write: m1 writes 0x48 to 0x8000_0000.
  - bus_write_enable=1 with bus_write_data=0x48 for exactly one cycle.
  - m1_ack 2 cycles after the request.
- Contention: m0 and m1 both request from reset and hold continuously.
  - Grant order is m0, m1, m0, m1.
  - grant is never 2'b11.
  - Strobes are never simultaneous.
- RD_LATENCY=3: slave data valid 3 cycles after the strobe with value 0xDEADBEEF_DEADBEEF.
  - m0_ack arrives 5 cycles after the request with that value.
  - Changing bus_read_data at latency-1 does not reach m0_rdata.
- Mid-transaction reset: assert reset during WAIT.
  - All outputs go 0 immediately (async).
  - No ack follows.
  - The next m1 request completes normally, with m0 having priority on a tie.
- Request drop: m1 deasserts req the cycle after the grant.
  - The transaction still completes and m1_ack pulses once.
  - The arbiter returns to IDLE with busy=0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the system bus: arbiter FSM states,
// master indices and the slave address map.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_IRQ = 1'b1;

  localparam logic [31:0] Rom_base = 32'h0000_0000;
  localparam logic [31:0] Ram_base = 32'h0000_1000;
  localparam logic [31:0] Stk_base = 32'h0000_2000;
  localparam logic [31:0] Art_base = 32'h8000_0000;
  localparam logic [31:0] Key_base = 32'h8000_0010;

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Master-side handshakes and slave-side bus signals of the two-master arbiter.
// The master modport is the environment view; the slave modport is the arbiter.
interface bus_master_arbiter_if #(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;

  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_write_data;
  logic          bus_write_enable;
  logic          bus_read_enable;
  logic [DW-1:0] bus_read_data;

  logic [1:0]    grant;
  logic          busy;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output bus_read_data,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    input  grant, busy
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  bus_read_data,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output bus_address, bus_write_data, bus_write_enable, bus_read_enable,
    output grant, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: a lone requester wins; on a tie the master
// that did not own the previous transaction wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c = 2'b00;
    case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = last_grant ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Shares the system bus between the CPU and the interrupt engine, one
// transaction at a time, returning read data RD_LATENCY cycles after the strobe.
module bus_master_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW         = 64,
  parameter int unsigned DW         = 64,
  parameter int unsigned RD_LATENCY = 0
) (
  input logic                 clk,
  input logic                 reset,
  bus_master_arbiter_if.slave bif
);

  localparam int unsigned CW = 3;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [1:0]    grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          ren_q, ren_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          busy_q, busy_d;

  logic [1:0]    win_c;
  logic          done_c;
  logic [DW-1:0] resp_data_c;

  rr_arb2 u_rr (
    .req       ({bif.m1_req, bif.m0_req}),
    .last_grant(last_q),
    .gnt_c     (win_c)
  );

  // Next state; strobes, acks and rdata default to 0 so they pulse for one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = '0;
    rdata1_d    = '0;
    done_c      = 1'b0;
    resp_data_c = '0;

    case (state_q)
      IDLE: begin
        if (|win_c) begin
          grant_d = win_c;
          we_d    = win_c[M_IRQ] ? bif.m1_we    : bif.m0_we;
          addr_d  = win_c[M_IRQ] ? bif.m1_addr  : bif.m0_addr;
          wdata_d = win_c[M_IRQ] ? bif.m1_wdata : bif.m0_wdata;
          wen_d   = we_d;
          ren_d   = ~we_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          done_c  = 1'b1;
          state_d = RESP;
        end else if (RD_LATENCY == 0) begin
          done_c      = 1'b1;
          resp_data_c = bif.bus_read_data;
          state_d     = RESP;
        end else begin
          cnt_d   = CW'(RD_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          done_c      = 1'b1;
          resp_data_c = bif.bus_read_data;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        last_d  = grant_q[M_IRQ];
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Route the completion to the owner only; writes return zero data.
    if (done_c) begin
      if (grant_q[M_IRQ]) begin
        ack1_d   = 1'b1;
        rdata1_d = resp_data_c;
      end else if (grant_q[M_CPU]) begin
        ack0_d   = 1'b1;
        rdata0_d = resp_data_c;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      grant_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  assign bif.bus_address      = addr_q;
  assign bif.bus_write_data   = wdata_q;
  assign bif.bus_write_enable = wen_q;
  assign bif.bus_read_enable  = ren_q;
  assign bif.grant            = grant_q;
  assign bif.busy             = busy_q;
  assign bif.m0_ack           = ack0_q;
  assign bif.m0_rdata         = rdata0_q;
  assign bif.m1_ack           = ack1_q;
  assign bif.m1_rdata         = rdata1_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: one instance with a combinational slave and
// one with a three-cycle slave, checked by vector table, scoreboard and sequences.
module tb_bus_master_arbiter;
  import cpu_bus_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_master_arbiter_if #(.AW(AW), .DW(DW)) b0 ();
  bus_master_arbiter_if #(.AW(AW), .DW(DW)) b3 ();

  bus_master_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .bif(b0.slave)
  );
  bus_master_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bif(b3.slave)
  );

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  typedef struct {
    bit          m;
    logic [63:0] rdata;
  } exp_t;
  exp_t sb0[$];
  exp_t sb_e;

  typedef struct {
    bit          m;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] slave;
    logic [63:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  localparam int NV = 6;
  vec_t vt[NV];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(bit m, bit req, bit we, logic [63:0] a, logic [63:0] d);
    if (m) begin
      b0.m1_req = req; b0.m1_we = we; b0.m1_addr = a; b0.m1_wdata = d;
    end else begin
      b0.m0_req = req; b0.m0_we = we; b0.m0_addr = a; b0.m0_wdata = d;
    end
  endtask

  // Scoreboard: every ack on the zero-latency instance must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (b0.m0_ack || b0.m1_ack)) begin
      if (sb0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb0_extra_ack: got ack m0=%0b m1=%0b required none", b0.m0_ack, b0.m1_ack);
      end else begin
        sb_e = sb0.pop_front();
        chk("sb0_master", {63'd0, b0.m1_ack}, {63'd0, sb_e.m});
        chk("sb0_rdata", b0.m1_ack ? b0.m1_rdata : b0.m0_rdata, sb_e.rdata);
      end
    end
  end

  // Exclusivity: never both strobes, never both acks, never both grants.
  always @(negedge clk) begin
    if ((b0.bus_write_enable && b0.bus_read_enable) || (b0.m0_ack && b0.m1_ack) ||
        (b0.grant == 2'b11) ||
        (b3.bus_write_enable && b3.bus_read_enable) || (b3.m0_ack && b3.m1_ack) ||
        (b3.grant == 2'b11))
      viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int          n, gi, acks, got, lat, got0, got1;
  logic [1:0]  prev;
  logic [1:0]  gseq[4];

  initial begin
    vt[0] = '{m:1'b0, we:1'b0, addr:64'h1004, wdata:64'h0,
              slave:64'h0000_0000_0000_1337, exp_rdata:64'h1337, exp_lat:2};
    vt[1] = '{m:1'b1, we:1'b1, addr:64'(Art_base), wdata:64'h48,
              slave:64'hFFFF, exp_rdata:64'h0, exp_lat:2};
    vt[2] = '{m:1'b1, we:1'b0, addr:64'(Key_base), wdata:64'h0,
              slave:64'h61, exp_rdata:64'h61, exp_lat:2};
    vt[3] = '{m:1'b0, we:1'b1, addr:64'(Ram_base) + 64'h8, wdata:64'hFFFF_FFFF_FFFF_FFFF,
              slave:64'h1234, exp_rdata:64'h0, exp_lat:2};
    vt[4] = '{m:1'b0, we:1'b0, addr:64'hFFFF_FFFF_FFFF_FFF8, wdata:64'h0,
              slave:64'h8000_0000_0000_0001, exp_rdata:64'h8000_0000_0000_0001, exp_lat:2};
    vt[5] = '{m:1'b1, we:1'b0, addr:64'(Rom_base), wdata:64'h5,
              slave:64'h0, exp_rdata:64'h0, exp_lat:2};

    b0.m0_req = 0; b0.m0_we = 0; b0.m0_addr = '0; b0.m0_wdata = '0;
    b0.m1_req = 0; b0.m1_we = 0; b0.m1_addr = '0; b0.m1_wdata = '0;
    b0.bus_read_data = '0;
    b3.m0_req = 0; b3.m0_we = 0; b3.m0_addr = '0; b3.m0_wdata = '0;
    b3.m1_req = 0; b3.m1_we = 0; b3.m1_addr = '0; b3.m1_wdata = '0;
    b3.bus_read_data = '0;

    #12;
    chk("rst_busy", b0.busy, 0);
    chk("rst_grant", b0.grant, 0);
    chk("rst_strobes", {b0.bus_write_enable, b0.bus_read_enable}, 0);
    chk("rst_acks", {b0.m0_ack, b0.m1_ack, b3.m0_ack, b3.m1_ack}, 0);
    chk("rst_addr", b0.bus_address, 0);
    chk("rst_rdata", b0.m0_rdata | b0.m1_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Contention from reset: m0 writes, m1 reads, both held high for four transactions.
    b0.bus_read_data = 64'h55;
    drive0(1'b0, 1'b1, 1'b1, 64'(Ram_base), 64'hA);
    drive0(1'b1, 1'b1, 1'b0, 64'(Key_base), 64'h0);
    sb0.push_back('{m:1'b0, rdata:64'h0});
    sb0.push_back('{m:1'b1, rdata:64'h55});
    sb0.push_back('{m:1'b0, rdata:64'h0});
    sb0.push_back('{m:1'b1, rdata:64'h55});
    n = 0; gi = 0; prev = 2'b00;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (b0.grant != 2'b00 && prev == 2'b00 && gi < 4) begin
        gseq[gi] = b0.grant;
        gi++;
      end
      prev = b0.grant;
      if (b0.m0_ack || b0.m1_ack) n++;
    end
    drive0(1'b0, 1'b0, 1'b1, 64'(Ram_base), 64'hA);
    drive0(1'b1, 1'b0, 1'b0, 64'(Key_base), 64'h0);
    chk("cont_acks", n, 4);
    chk("cont_grant0", gseq[0], 2'b01);
    chk("cont_grant1", gseq[1], 2'b10);
    chk("cont_grant2", gseq[2], 2'b01);
    chk("cont_grant3", gseq[3], 2'b10);
    tick();
    chk("cont_idle", b0.busy, 0);

    // Single-master transactions from the vector table.
    for (int i = 0; i < NV; i++) begin
      b0.bus_read_data = vt[i].slave;
      drive0(vt[i].m, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
      sb0.push_back('{m:vt[i].m, rdata:vt[i].exp_rdata});
      got = 0; lat = 0;
      for (int c = 1; c <= 8 && got == 0; c++) begin
        tick();
        if (c == 1) begin
          chk($sformatf("v%0d_wen", i), b0.bus_write_enable, vt[i].we);
          chk($sformatf("v%0d_ren", i), b0.bus_read_enable, !vt[i].we);
          chk($sformatf("v%0d_addr", i), b0.bus_address, vt[i].addr);
          if (vt[i].we) chk($sformatf("v%0d_wdata", i), b0.bus_write_data, vt[i].wdata);
          chk($sformatf("v%0d_grant", i), b0.grant, vt[i].m ? 2'b10 : 2'b01);
        end
        if (c == 2)
          chk($sformatf("v%0d_strobe_off", i), {b0.bus_write_enable, b0.bus_read_enable}, 0);
        if (b0.m0_ack || b0.m1_ack) begin
          got = 1;
          lat = c;
          drive0(vt[i].m, 1'b0, vt[i].we, vt[i].addr, vt[i].wdata);
        end
      end
      if (got == 0) begin
        checks++;
        failures++;
        $display("FAIL v%0d_timeout: got no ack required ack within 8 cycles", i);
        drive0(vt[i].m, 1'b0, vt[i].we, vt[i].addr, vt[i].wdata);
      end else begin
        chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      end
      tick();
      chk($sformatf("v%0d_idle", i), b0.busy, 0);
    end

    // m1 drops req right after the grant; the transaction still completes once.
    b0.bus_read_data = 64'h99;
    drive0(1'b1, 1'b1, 1'b0, 64'(Key_base), 64'h0);
    sb0.push_back('{m:1'b1, rdata:64'h99});
    tick();
    chk("drop_grant", b0.grant, 2'b10);
    drive0(1'b1, 1'b0, 1'b0, 64'(Key_base), 64'h0);
    acks = 0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      if (b0.m1_ack) acks++;
    end
    chk("drop_ack_count", acks, 1);
    chk("drop_idle", b0.busy, 0);

    // Three-cycle slave: only the value present at the capture edge reaches m0.
    b3.bus_read_data = 64'h1111;
    b3.m0_we = 1'b0; b3.m0_addr = 64'h1004; b3.m0_req = 1'b1;
    got = 0; lat = 0;
    for (int c = 1; c <= 12 && got == 0; c++) begin
      tick();
      if (c == 1) chk("l3_ren", b3.bus_read_enable, 1);
      if (c == 2) chk("l3_wait_strobe", b3.bus_read_enable, 0);
      if (c == 3) chk("l3_busy", b3.busy, 1);
      if (c == 3) b3.bus_read_data = 64'h0BAD;
      if (c == 4) b3.bus_read_data = 64'hDEADBEEF_DEADBEEF;
      if (c == 5) b3.bus_read_data = 64'h0;
      if (b3.m0_ack) begin
        got = 1;
        lat = c;
        chk("l3_rdata", b3.m0_rdata, 64'hDEADBEEF_DEADBEEF);
        chk("l3_m1_ack", b3.m1_ack, 0);
        b3.m0_req = 1'b0;
      end
    end
    chk("l3_latency", lat, 5);
    tick();
    chk("l3_idle", b3.busy, 0);

    // Reset during WAIT drops the transaction with no ack.
    b3.bus_read_data = 64'h2222;
    b3.m1_we = 1'b0; b3.m1_addr = 64'(Key_base); b3.m1_req = 1'b1;
    tick();
    tick();
    chk("mr_busy_pre", b3.busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mr_busy", b3.busy, 0);
    chk("mr_grant", b3.grant, 0);
    chk("mr_addr", b3.bus_address, 0);
    chk("mr_strobes", {b3.bus_write_enable, b3.bus_read_enable}, 0);
    b3.m1_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (b3.m0_ack || b3.m1_ack) acks++;
    end
    chk("mr_no_ack", acks, 0);

    // Tie after reset: m0 first, then m1.
    b3.bus_read_data = 64'h77;
    b3.m0_we = 1'b0; b3.m0_addr = 64'(Stk_base); b3.m0_req = 1'b1;
    b3.m1_req = 1'b1;
    tick();
    chk("mr_tie_grant", b3.grant, 2'b01);
    got0 = 0; got1 = 0;
    for (int c = 2; c <= 20 && got1 == 0; c++) begin
      tick();
      if (b3.m0_ack) begin
        got0 = c;
        chk("mr_m0_rdata", b3.m0_rdata, 64'h77);
        b3.m0_req = 1'b0;
      end
      if (b3.m1_ack) begin
        got1 = c;
        chk("mr_m1_rdata", b3.m1_rdata, 64'h77);
        b3.m1_req = 1'b0;
      end
    end
    chk("mr_m0_lat", got0, 5);
    chk("mr_m1_lat", got1, 11);
    tick();
    chk("mr_idle", b3.busy, 0);

    tick();
    chk("sb0_empty", sb0.size(), 0);
    chk("exclusivity", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
